// File: rtl/fixed_point_divider_param.sv
// Sequential restoring fixed-point divider: Q = A / B, W-bit operands with FRAC fractional bits.
// Optional two's-complement operands when FIXED_POINT_DIVIDER_SIGNED_EN is defined.
module fixed_point_divider_param #(
    parameter int W    = 10,
    parameter int FRAC = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         ld_a,
    input  logic         ld_b,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] q,
    output logic         ov,
    output logic         dz,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);
    localparam int N  = W + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q;
    logic [W-1:0]   a_q, b_q, dvs_q, q_q;
    logic [N-1:0]   dvd_q;
    logic [W-1:0]   rem_q;
    // The quotient keeps N-1 bits; the final step's bit completes the N-bit value in quo_d.
    logic [N-2:0]   quo_q;
    logic [CW-1:0]  cnt_q;
    logic           ov_q, dz_q, busy_q, done_q;

    logic [W:0]     rem_sh_d;
    logic           take_d;
    logic [W-1:0]   rem_d;
    logic [N-1:0]   quo_d;
    logic [W-1:0]   res_q_d;
    logic           res_ov_d;
    logic [W-1:0]   a_mag_d, b_mag_d, dz_val_d;

`ifdef FIXED_POINT_DIVIDER_SIGNED_EN
    localparam logic [N-1:0] HALF = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    logic neg_q;
`endif

    always_comb begin
        rem_sh_d = {rem_q, dvd_q[N-1]};
        take_d   = rem_sh_d >= {1'b0, dvs_q};
        // The difference is below the divisor, so it always fits in W bits.
        rem_d    = take_d ? (rem_sh_d[W-1:0] - dvs_q) : rem_sh_d[W-1:0];
        quo_d    = {quo_q, take_d};
`ifdef FIXED_POINT_DIVIDER_SIGNED_EN
        a_mag_d  = a_q[W-1] ? (~a_q + ONE_W) : a_q;
        b_mag_d  = b_q[W-1] ? (~b_q + ONE_W) : b_q;
        dz_val_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        // A negative result may reach exactly 2^(W-1); a positive one may not.
        res_ov_d = neg_q ? (quo_d > HALF) : (quo_d >= HALF);
        res_q_d  = neg_q ? (~quo_d[W-1:0] + ONE_W) : quo_d[W-1:0];
`else
        a_mag_d  = a_q;
        b_mag_d  = b_q;
        dz_val_d = {W{1'b1}};
        res_ov_d = |quo_d[N-1:W];
        res_q_d  = quo_d[W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIXED_POINT_DIVIDER_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ld_a) a_q <= a_in;
                    if (ld_b) b_q <= b_in;
                    // start works on the operands held before this edge.
                    if (start) begin
                        busy_q <= 1'b1;
                        if (b_q == '0) begin
                            state_q <= DONE;
                            q_q     <= dz_val_d;
                            ov_q    <= 1'b0;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            dvd_q   <= {a_mag_d, {FRAC{1'b0}}};
                            dvs_q   <= b_mag_d;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            cnt_q   <= CW'(N);
                            dz_q    <= 1'b0;
`ifdef FIXED_POINT_DIVIDER_SIGNED_EN
                            neg_q   <= a_q[W-1] ^ b_q[W-1];
`endif
                        end
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[N-2:0], 1'b0};
                    rem_q <= rem_d;
                    quo_q <= quo_d[N-2:0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        q_q     <= res_q_d;
                        ov_q    <= res_ov_d;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q         = q_q;
    assign ov        = ov_q;
    assign dz        = dz_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_fixed_point_divider_param.sv
// Directed and random checks of fixed_point_divider_param against an arithmetic reference model.
module tb_fixed_point_divider_param;
    localparam int W    = 10;
    localparam int FRAC = 5;
    localparam int N    = W + FRAC;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, ld_a, ld_b;
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] q;
    logic         ov, dz, busy, done;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    fixed_point_divider_param #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_a(ld_a), .ld_b(ld_b),
        .a_in(a_in), .b_in(b_in), .q(q), .ov(ov), .dz(dz), .busy(busy),
        .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient = (A * 2^FRAC) / B in plain integer arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic eov, output logic edz);
        longint full;
`ifdef FIXED_POINT_DIVIDER_SIGNED_EN
        longint sa, sb, mag, lim;
        logic   neg;
        sa  = $signed(a);
        sb  = $signed(b);
        lim = longint'(1) << (W - 1);
        if (b == '0) begin
            full = (sa < 0) ? lim : lim - 1;
            eq   = full[W-1:0];
            eov  = 1'b0;
            edz  = 1'b1;
        end else begin
            mag  = ((sa < 0 ? -sa : sa) << FRAC) / (sb < 0 ? -sb : sb);
            neg  = (sa < 0) != (sb < 0);
            eov  = neg ? (mag > lim) : (mag > lim - 1);
            full = neg ? -mag : mag;
            eq   = full[W-1:0];
            edz  = 1'b0;
        end
`else
        if (b == '0) begin
            eq  = {W{1'b1}};
            eov = 1'b0;
            edz = 1'b1;
        end else begin
            full = (longint'(a) << FRAC) / longint'(b);
            eq   = full[W-1:0];
            eov  = full >= (longint'(1) << W);
            edz  = 1'b0;
        end
`endif
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        ld_a = 1'b1; ld_b = 1'b1; a_in = a; b_in = b;
        tick();
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    // Starts a division on registers holding a/b; optionally pokes start/ld_a while busy.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit poke_busy, output logic [W-1:0] got_q);
        logic [W-1:0] eq;
        logic         eov, edz;
        int           lat;
        model(a, b, eq, eov, edz);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 32'(1));
        lat = 0;
        while (!done && lat < 4 * N) begin
            if (poke_busy && lat == 3) begin
                start = 1'b1; ld_a = 1'b1; ld_b = 1'b1; a_in = ~a; b_in = '0;
            end else begin
                start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        check({tag, ".latency"}, 32'(lat), (b == '0) ? 32'(0) : 32'(N));
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".ov"}, 32'(ov), 32'(eov));
        check({tag, ".dz"}, 32'(dz), 32'(edz));
        got_q = q;
        tick();
        check({tag, ".done_fall"}, 32'(done), 32'(0));
        check({tag, ".busy_fall"}, 32'(busy), 32'(0));
        check({tag, ".q_held"}, 32'(q), 32'(eq));
    endtask

    initial begin
        logic [W-1:0] r, ra, rb;
        rst = 1'b0; start = 1'b0; ld_a = 1'b0; ld_b = 1'b0; a_in = '0; b_in = '0;
        #12;
        check("reset.q", 32'(q), 32'(0));
        check("reset.ov", 32'(ov), 32'(0));
        check("reset.dz", 32'(dz), 32'(0));
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.done", 32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

`ifndef FIXED_POINT_DIVIDER_SIGNED_EN
        load_ops(10'b0000100000, 10'b0000010000);
        run_div("one_by_half", 10'b0000100000, 10'b0000010000, 1'b0, r);
        check("one_by_half.const", 32'(r), 32'(10'b0001000000));
        load_ops(10'b0011110000, 10'b0000110000);
        run_div("7p5_by_1p5", 10'b0011110000, 10'b0000110000, 1'b0, r);
        check("7p5_by_1p5.const", 32'(r), 32'(10'b0010100000));
        load_ops(10'b1111111111, 10'b0000000001);
        run_div("overflow", 10'b1111111111, 10'b0000000001, 1'b0, r);
        check("overflow.const", 32'(r), 32'(10'b1111100000));
        check("overflow.ov_const", 32'(ov), 32'(1));
`else
        load_ops(10'b1111100000, 10'b0000010000);
        run_div("signed_m1_by_half", 10'b1111100000, 10'b0000010000, 1'b0, r);
        check("signed_m1_by_half.const", 32'(r), 32'(10'b1111000000));
        load_ops(10'b1000000000, 10'b0000100000);
        run_div("signed_most_neg", 10'b1000000000, 10'b0000100000, 1'b0, r);
`endif

        load_ops(10'b0000100000, 10'b0000000000);
        run_div("div_zero", 10'b0000100000, 10'b0000000000, 1'b0, r);
        load_ops(10'b0000100000, 10'b0000010000);
        run_div("after_dz", 10'b0000100000, 10'b0000010000, 1'b0, r);

        // Loads ride along with start but only affect the following division.
        ld_a = 1'b1; ld_b = 1'b1; a_in = 10'b0011110000; b_in = 10'b0000110000;
        run_div("same_edge_old", 10'b0000100000, 10'b0000010000, 1'b0, r);
        run_div("same_edge_new", 10'b0011110000, 10'b0000110000, 1'b0, r);

        run_div("poke_busy", 10'b0011110000, 10'b0000110000, 1'b1, r);
        run_div("back_to_back", 10'b0011110000, 10'b0000110000, 1'b0, r);

        // Reset asserted five cycles into a division.
        load_ops(10'b0011110000, 10'b0000110000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midreset.q", 32'(q), 32'(0));
        check("midreset.ov", 32'(ov), 32'(0));
        check("midreset.dz", 32'(dz), 32'(0));
        check("midreset.busy", 32'(busy), 32'(0));
        check("midreset.done", 32'(done), 32'(0));
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done) check("midreset.no_done", 32'(done), 32'(0));
        end
        #2;
        rst = 1'b1;
        tick();
        load_ops(10'b0011110000, 10'b0000110000);
        run_div("after_reset", 10'b0011110000, 10'b0000110000, 1'b0, r);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
            load_ops(ra, rb);
            run_div($sformatf("rand%0d", i), ra, rb, 1'b0, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
